// File: rtl/snn_out_pkg.sv
// ============================================================================
// Module : snn_out_pkg
// Brief  : Shared types and helpers for the SNN output accumulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package snn_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Class index width; never narrower than one bit.
    function automatic int cls_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [127:0] sat_max(input int w);
        return (128'sd1 <<< (w - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] sat_min(input int w);
        return -(128'sd1 <<< (w - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/snn_sat_add.sv
// ============================================================================
// Module : snn_sat_add
// Brief  : Signed potential + weight adder with clamp and saturation flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module snn_sat_add
    import snn_out_pkg::*;
#(
    parameter int DATA_W   = 48,
    parameter int WEIGHT_W = 16
) (
    input  logic signed [DATA_W-1:0]   acc,
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic signed [DATA_W-1:0]   sum,
    output logic                       sat
);

    localparam logic signed [DATA_W-1:0] c_max = DATA_W'(sat_max(DATA_W));
    localparam logic signed [DATA_W-1:0] c_min = DATA_W'(sat_min(DATA_W));

    logic signed [DATA_W:0] w_wide;
    logic                   w_pos_ovf;
    logic                   w_neg_ovf;

    // One guard bit: overflow iff the two top bits disagree.
    assign w_wide    = {acc[DATA_W-1], acc} + (DATA_W+1)'(weight);
    assign w_pos_ovf = ~w_wide[DATA_W] &  w_wide[DATA_W-1];
    assign w_neg_ovf =  w_wide[DATA_W] & ~w_wide[DATA_W-1];

    assign sum = w_pos_ovf ? c_max : (w_neg_ovf ? c_min : w_wide[DATA_W-1:0]);
    assign sat = w_pos_ovf | w_neg_ovf;

endmodule

`default_nettype wire

// File: rtl/snn_output_accumulator.sv
// ============================================================================
// Module : snn_output_accumulator
// Brief  : Per-class signed membrane integration over NUM_STEPS timesteps,
//          emitting the potential vector with a one-cycle o_valid pulse.
//          Optional leak per timestep when SNN_OUT_LEAK_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module snn_output_accumulator
    import snn_out_pkg::*;
#(
    parameter int VEC_LEN    = 3,
    parameter int DATA_W     = 48,
    parameter int WEIGHT_W   = 16,
    parameter int NUM_STEPS  = 32,
    parameter int LEAK_SHIFT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic                        i_syn_valid,
    input  logic [cls_w(VEC_LEN)-1:0]   i_syn_class,
    input  logic signed [WEIGHT_W-1:0]  i_syn_weight,
    input  logic                        i_step_end,
    output logic                        o_busy,
    output logic                        o_valid,
    output logic [VEC_LEN*DATA_W-1:0]   o_potentials_flat,
    output logic                        o_sat
);

    localparam int c_cls_w = cls_w(VEC_LEN);
    localparam int c_cnt_w = $clog2(NUM_STEPS + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_STEPS - 1);

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_acc [VEC_LEN];
    logic [c_cnt_w-1:0]        r_step;
    logic                      r_busy;
    logic                      r_valid;
    logic                      r_sat;
    logic [VEC_LEN*DATA_W-1:0] r_flat;

    logic                      w_cls_ok;
    logic [c_cls_w-1:0]        w_idx;
    logic                      w_hit;
    logic signed [DATA_W-1:0]  w_sum;
    logic                      w_add_sat;
    logic signed [DATA_W-1:0]  w_post [VEC_LEN];
    logic signed [DATA_W-1:0]  w_step_val [VEC_LEN];

    assign w_cls_ok = ({1'b0, i_syn_class} < (c_cls_w+1)'(VEC_LEN));
    assign w_idx    = w_cls_ok ? i_syn_class : '0;
    assign w_hit    = (r_state == ACCUM) && i_syn_valid && w_cls_ok;

    snn_sat_add #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W)
    ) u_sat_add (
        .acc    (r_acc[w_idx]),
        .weight (i_syn_weight),
        .sum    (w_sum),
        .sat    (w_add_sat)
    );

    always_comb begin
        for (int k = 0; k < VEC_LEN; k++) begin
            w_post[k] = (w_hit && (w_idx == c_cls_w'(k))) ? w_sum : r_acc[k];
        end
    end

`ifdef SNN_OUT_LEAK_EN
    // Leak applies to the post-add value, so a same-cycle event decays too.
    for (genvar k = 0; k < VEC_LEN; k++) begin : g_leak
        assign w_step_val[k] = w_post[k] - (w_post[k] >>> LEAK_SHIFT);
    end
`else
    for (genvar k = 0; k < VEC_LEN; k++) begin : g_no_leak
        assign w_step_val[k] = w_post[k];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            r_flat  <= '0;
            for (int k = 0; k < VEC_LEN; k++) r_acc[k] <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= ACCUM;
                        r_busy  <= 1'b1;
                        r_step  <= '0;
                        r_sat   <= 1'b0;
                        for (int k = 0; k < VEC_LEN; k++) r_acc[k] <= '0;
                    end
                end
                ACCUM: begin
                    if (i_start) begin
                        r_step <= '0;
                        r_sat  <= 1'b0;
                        for (int k = 0; k < VEC_LEN; k++) r_acc[k] <= '0;
                    end else begin
                        if (w_hit && w_add_sat) r_sat <= 1'b1;
                        if (i_step_end) begin
                            for (int k = 0; k < VEC_LEN; k++) r_acc[k] <= w_step_val[k];
                            r_step <= r_step + 1'b1;
                            if (r_step == c_last) r_state <= EMIT;
                        end else begin
                            for (int k = 0; k < VEC_LEN; k++) r_acc[k] <= w_post[k];
                        end
                    end
                end
                EMIT: begin
                    r_valid <= 1'b1;
                    for (int k = 0; k < VEC_LEN; k++) r_flat[k*DATA_W +: DATA_W] <= r_acc[k];
                    // A start here still lets the emit complete before restarting.
                    if (i_start) begin
                        r_state <= ACCUM;
                        r_step  <= '0;
                        r_sat   <= 1'b0;
                        for (int k = 0; k < VEC_LEN; k++) r_acc[k] <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy            = r_busy;
    assign o_valid           = r_valid;
    assign o_potentials_flat = r_flat;
    assign o_sat             = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_snn_output_accumulator.sv
// ============================================================================
// Module : tb_snn_output_accumulator
// Brief  : Directed self-checking bench for snn_output_accumulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_snn_output_accumulator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              syn_valid;
    logic [1:0]        syn_class;
    logic signed [15:0] syn_weight;
    logic              step_end;

    logic              a_busy, a_valid, a_sat;
    logic [143:0]      a_flat;
    logic              b_busy, b_valid, b_sat;
    logic [23:0]       b_flat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snn_output_accumulator #(
        .VEC_LEN(3), .DATA_W(48), .WEIGHT_W(16), .NUM_STEPS(2), .LEAK_SHIFT(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_syn_valid(syn_valid),
        .i_syn_class(syn_class), .i_syn_weight(syn_weight), .i_step_end(step_end),
        .o_busy(a_busy), .o_valid(a_valid), .o_potentials_flat(a_flat), .o_sat(a_sat)
    );

    snn_output_accumulator #(
        .VEC_LEN(3), .DATA_W(8), .WEIGHT_W(16), .NUM_STEPS(2), .LEAK_SHIFT(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_syn_valid(syn_valid),
        .i_syn_class(syn_class), .i_syn_weight(syn_weight), .i_step_end(step_end),
        .o_busy(b_busy), .o_valid(b_valid), .o_potentials_flat(b_flat), .o_sat(b_sat)
    );

    function automatic longint lk(input longint v);
`ifdef SNN_OUT_LEAK_EN
        return v - (v >>> 1);
`else
        return v;
`endif
    endfunction

    function automatic logic [143:0] vec_a(input longint c2, input longint c1, input longint c0);
        return {48'(c2), 48'(c1), 48'(c0)};
    endfunction

    function automatic logic [23:0] vec_b(input longint c2, input longint c1, input longint c0);
        return {8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, sample 1ns after the edge, then idle inputs.
    task automatic cyc(input logic st, input logic v, input logic [1:0] c,
                       input int w, input logic se);
        start = st; syn_valid = v; syn_class = c; syn_weight = 16'(w); step_end = se;
        @(posedge clk);
        #1;
        start = 1'b0; syn_valid = 1'b0; syn_class = '0; syn_weight = '0; step_end = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; syn_valid = 1'b0; syn_class = '0; syn_weight = '0; step_end = 1'b0;
        #12;
        chk("rst_valid", 144'(a_valid), 144'(0));
        chk("rst_busy",  144'(a_busy),  144'(0));
        chk("rst_flat",  a_flat,        144'(0));
        chk("rst_sat",   144'(a_sat),   144'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic two-step integration.
        cyc(1, 0, 0, 0, 0);
        chk("t1_busy", 144'(a_busy), 144'(1));
        cyc(0, 1, 0, 5, 0);
        cyc(0, 1, 2, 7, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 1, -3, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t1_valid_e0", 144'(a_valid), 144'(0));
        chk("t1_busy_emit", 144'(a_busy), 144'(1));
        cyc(0, 0, 0, 0, 0);
        chk("t1_valid_e1", 144'(a_valid), 144'(1));
        chk("t1_vec", a_flat, vec_a(lk(lk(7)), lk(-3), lk(lk(5))));
        chk("t1_sat", 144'(a_sat), 144'(0));
        chk("t1_idle", 144'(a_busy), 144'(0));
        cyc(0, 0, 0, 0, 0);
        chk("t1_valid_e2", 144'(a_valid), 144'(0));
        chk("t1_hold", a_flat, vec_a(lk(lk(7)), lk(-3), lk(lk(5))));

        // Dropped IDLE/out-of-range events; event on the final step_end.
        cyc(0, 1, 0, 50, 0);
        chk("t5_idle_drop", 144'(a_valid), 144'(0));
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 3, 99, 0);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 1, 2, 1);
        chk("t3_valid_e0", 144'(a_valid), 144'(0));
        cyc(0, 0, 0, 0, 0);
        chk("t3_valid_e1", 144'(a_valid), 144'(1));
        chk("t3_vec", a_flat, vec_a(0, lk(2), lk(lk(1))));

        // Restart mid-ACCUM discards the earlier contribution.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 9, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t4_no_valid", 144'(a_valid), 144'(0));
        chk("t4_busy", 144'(a_busy), 144'(1));
        cyc(0, 1, 0, 4, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t4_valid_e0", 144'(a_valid), 144'(0));
        cyc(0, 0, 0, 0, 0);
        chk("t4_valid_e1", 144'(a_valid), 144'(1));
        chk("t4_vec", a_flat, vec_a(0, 0, lk(lk(4))));

        // Saturation on the 8-bit instance.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 100, 0);
        chk("t2_sat_pre", 144'(b_sat), 144'(0));
        cyc(0, 1, 1, 100, 0);
        chk("t2_sat_set", 144'(b_sat), 144'(1));
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t2_valid", 144'(b_valid), 144'(1));
        chk("t2_vec", 144'(b_flat), 144'(vec_b(0, lk(lk(127)), 0)));
        chk("t2_sat_hold", 144'(b_sat), 144'(1));
        cyc(1, 0, 0, 0, 0);
        chk("t2_sat_clr", 144'(b_sat), 144'(0));

        // Asynchronous reset mid-inference.
        cyc(0, 1, 0, 5, 0);
        cyc(0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_busy",  144'(a_busy),  144'(0));
        chk("rst2_valid", 144'(a_valid), 144'(0));
        chk("rst2_flat",  a_flat,        144'(0));
        chk("rst2_bsat",  144'(b_sat),   144'(0));
        #10 rst_n = 1'b1;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("rst2_no_valid", 144'(a_valid), 144'(0));
        chk("rst2_idle", 144'(a_busy), 144'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
